// File: rtl/masked_speck_bitserial_core.sv
// Two-share, first-order masked, bit-serial Speck encryption core for every Speck block/key size.
// Build macro SPECK_FRESH_RND_EN: when defined, rnd feeds the shared carry ANDs; otherwise r is forced to 0.
module masked_speck_bitserial_core #(
  parameter int WORD      = 64,
  parameter int KEY_WORDS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*WORD-1:0]         pt_a,
  input  logic [2*WORD-1:0]         pt_b,
  input  logic [KEY_WORDS*WORD-1:0] key_a,
  input  logic [KEY_WORDS*WORD-1:0] key_b,
  input  logic [1:0]                rnd,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [2*WORD-1:0]         ct_a,
  output logic [2*WORD-1:0]         ct_b
);

  function automatic int speck_rounds(input int w, input int m);
    case (w)
      16:      return 22;
      24:      return (m == 3) ? 22 : 23;
      32:      return (m == 3) ? 26 : 27;
      48:      return (m == 2) ? 28 : 29;
      default: return 30 + m;
    endcase
  endfunction

  localparam int ALPHA  = (WORD == 16) ? 7 : 8;
  localparam int BETA   = (WORD == 16) ? 2 : 3;
  localparam int ROUNDS = speck_rounds(WORD, KEY_WORDS);
  localparam int BW     = $clog2(WORD);
  localparam int RCW    = $clog2(ROUNDS);
  localparam int LW     = (KEY_WORDS - 1) * WORD;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [BW-1:0]        bit_q;
  logic [RCW-1:0]       round_q;
  logic [1:0][WORD-1:0] x_q, y_q, k_q;
  logic [1:0][WORD-2:0] xn_q, yn_q, kn_q, ln_q;
  logic [1:0][LW-1:0]   l_q;
  logic [1:0]           cr_q, ck_q;

  logic last_bit, last_round;
  assign last_bit   = (bit_q == BW'(WORD - 1));
  assign last_round = (round_q == RCW'(ROUNDS - 1));

  logic r_rnd, r_key;
`ifdef SPECK_FRESH_RND_EN
  assign {r_key, r_rnd} = rnd;
`else
  assign {r_key, r_rnd} = rnd & 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !done;
        if (start && !done) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit && last_round) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [BW-1:0]        ia, ib;
  logic [WORD-1:0]      rc;
  logic [1:0][WORD-1:0] l_cur, x_nxt, y_nxt, k_nxt, l_nxt;
  logic [1:0]           ur, vr, pr, qr, sr, uk, vk, pk, qk, sk;
  logic [1:0]           xb, yb, lb, kb, cr_d, ck_d;

  always_comb begin
    // ia selects the ROR-by-ALPHA source bit, ib the ROL-by-BETA source bit, for bit position bit_q
    ia = (bit_q >= BW'(WORD - ALPHA)) ? bit_q - BW'(WORD - ALPHA) : bit_q + BW'(ALPHA);
    ib = (bit_q >= BW'(BETA)) ? bit_q - BW'(BETA) : bit_q + BW'(WORD - BETA);
    rc = WORD'(round_q);
    l_cur[0] = l_q[0][WORD-1:0];
    l_cur[1] = l_q[1][WORD-1:0];

    ur = {x_q[1][ia], x_q[0][ia]};
    vr = {y_q[1][bit_q], y_q[0][bit_q]};
    pr = ur ^ cr_q;
    qr = vr ^ cr_q;
    sr = ur ^ vr ^ cr_q;
    // cross-share products are refreshed with r before joining the share's own terms
    cr_d[0] = (pr[0] & qr[0]) ^ ((pr[0] & qr[1]) ^ r_rnd) ^ cr_q[0];
    cr_d[1] = (pr[1] & qr[1]) ^ ((pr[1] & qr[0]) ^ r_rnd) ^ cr_q[1];

    uk = {k_q[1][bit_q], k_q[0][bit_q]};
    vk = {l_cur[1][ia], l_cur[0][ia]};
    pk = uk ^ ck_q;
    qk = vk ^ ck_q;
    sk = uk ^ vk ^ ck_q;
    ck_d[0] = (pk[0] & qk[0]) ^ ((pk[0] & qk[1]) ^ r_key) ^ ck_q[0];
    ck_d[1] = (pk[1] & qk[1]) ^ ((pk[1] & qk[0]) ^ r_key) ^ ck_q[1];

    xb = sr ^ uk;
    yb = {y_q[1][ib], y_q[0][ib]} ^ xb;
    lb = sk ^ {1'b0, rc[bit_q]};
    kb = {k_q[1][ib], k_q[0][ib]} ^ lb;

    x_nxt[0] = {xb[0], xn_q[0]};
    x_nxt[1] = {xb[1], xn_q[1]};
    y_nxt[0] = {yb[0], yn_q[0]};
    y_nxt[1] = {yb[1], yn_q[1]};
    k_nxt[0] = {kb[0], kn_q[0]};
    k_nxt[1] = {kb[1], kn_q[1]};
    l_nxt[0] = {lb[0], ln_q[0]};
    l_nxt[1] = {lb[1], ln_q[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      round_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      l_q     <= '0;
      xn_q    <= '0;
      yn_q    <= '0;
      kn_q    <= '0;
      ln_q    <= '0;
      cr_q    <= '0;
      ck_q    <= '0;
      done    <= 1'b0;
      ct_a    <= '0;
      ct_b    <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && ready) begin
            x_q[0]  <= pt_a[2*WORD-1:WORD];
            y_q[0]  <= pt_a[WORD-1:0];
            x_q[1]  <= pt_b[2*WORD-1:WORD];
            y_q[1]  <= pt_b[WORD-1:0];
            k_q[0]  <= key_a[WORD-1:0];
            l_q[0]  <= key_a[KEY_WORDS*WORD-1:WORD];
            k_q[1]  <= key_b[WORD-1:0];
            l_q[1]  <= key_b[KEY_WORDS*WORD-1:WORD];
            bit_q   <= '0;
            round_q <= '0;
            cr_q    <= '0;
            ck_q    <= '0;
          end
        end
        RUN: begin
          // new-word bits shift in from the top so the LSB lands at bit 0 on the last cycle
          xn_q[0] <= x_nxt[0][WORD-1:1];
          xn_q[1] <= x_nxt[1][WORD-1:1];
          yn_q[0] <= y_nxt[0][WORD-1:1];
          yn_q[1] <= y_nxt[1][WORD-1:1];
          kn_q[0] <= k_nxt[0][WORD-1:1];
          kn_q[1] <= k_nxt[1][WORD-1:1];
          ln_q[0] <= l_nxt[0][WORD-1:1];
          ln_q[1] <= l_nxt[1][WORD-1:1];
          if (last_bit) begin
            bit_q   <= '0;
            round_q <= round_q + RCW'(1);
            cr_q    <= '0;
            ck_q    <= '0;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            k_q     <= k_nxt;
            l_q[0]  <= LW'({l_nxt[0], l_q[0]} >> WORD);
            l_q[1]  <= LW'({l_nxt[1], l_q[1]} >> WORD);
          end else begin
            bit_q <= bit_q + BW'(1);
            cr_q  <= cr_d;
            ck_q  <= ck_d;
          end
        end
        DONE: begin
          ct_a <= {x_q[0], y_q[0]};
          ct_b <= {x_q[1], y_q[1]};
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_speck_bitserial_core.sv
// Scoreboard bench for the masked bit-serial Speck core: 128/128, 32/64, 64/128 and 128/256 instances.
module tb_masked_speck_bitserial_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rnd = 2'b00;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         d128_start = 0, d128_ready, d128_busy, d128_done;
  logic [127:0] d128_pt_a = '0, d128_pt_b = '0, d128_key_a = '0, d128_key_b = '0, d128_ct_a, d128_ct_b;
  logic         d32_start = 0, d32_ready, d32_busy, d32_done;
  logic [31:0]  d32_pt_a = '0, d32_pt_b = '0, d32_ct_a, d32_ct_b;
  logic [63:0]  d32_key_a = '0, d32_key_b = '0;
  logic         d64_start = 0, d64_ready, d64_busy, d64_done;
  logic [63:0]  d64_pt_a = '0, d64_pt_b = '0, d64_ct_a, d64_ct_b;
  logic [127:0] d64_key_a = '0, d64_key_b = '0;
  logic         d256_start = 0, d256_ready, d256_busy, d256_done;
  logic [127:0] d256_pt_a = '0, d256_pt_b = '0, d256_ct_a, d256_ct_b;
  logic [255:0] d256_key_a = '0, d256_key_b = '0;

  masked_speck_bitserial_core #(.WORD(64), .KEY_WORDS(2)) u_d128 (
    .clk(clk), .rst(rst), .start(d128_start), .pt_a(d128_pt_a), .pt_b(d128_pt_b),
    .key_a(d128_key_a), .key_b(d128_key_b), .rnd(rnd), .ready(d128_ready), .busy(d128_busy),
    .done(d128_done), .ct_a(d128_ct_a), .ct_b(d128_ct_b));
  masked_speck_bitserial_core #(.WORD(16), .KEY_WORDS(4)) u_d32 (
    .clk(clk), .rst(rst), .start(d32_start), .pt_a(d32_pt_a), .pt_b(d32_pt_b),
    .key_a(d32_key_a), .key_b(d32_key_b), .rnd(rnd), .ready(d32_ready), .busy(d32_busy),
    .done(d32_done), .ct_a(d32_ct_a), .ct_b(d32_ct_b));
  masked_speck_bitserial_core #(.WORD(32), .KEY_WORDS(4)) u_d64 (
    .clk(clk), .rst(rst), .start(d64_start), .pt_a(d64_pt_a), .pt_b(d64_pt_b),
    .key_a(d64_key_a), .key_b(d64_key_b), .rnd(rnd), .ready(d64_ready), .busy(d64_busy),
    .done(d64_done), .ct_a(d64_ct_a), .ct_b(d64_ct_b));
  masked_speck_bitserial_core #(.WORD(64), .KEY_WORDS(4)) u_d256 (
    .clk(clk), .rst(rst), .start(d256_start), .pt_a(d256_pt_a), .pt_b(d256_pt_b),
    .key_a(d256_key_a), .key_b(d256_key_b), .rnd(rnd), .ready(d256_ready), .busy(d256_busy),
    .done(d256_done), .ct_a(d256_ct_a), .ct_b(d256_ct_b));

  // ROUNDS*WORD+1 edges from accept to done: 32*64+1, 22*16+1, 27*32+1, 34*64+1
  localparam int unsigned LAT [4] = '{2049, 353, 865, 2177};

  localparam logic [127:0] PT128  = 128'h6c617669757165207469206564616d20;
  localparam logic [255:0] K128   = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT128  = 128'ha65d9851797832657860fedf5c570d18;
  localparam logic [127:0] PT32   = 128'h6574694c;
  localparam logic [255:0] K32    = 256'h1918111009080100;
  localparam logic [127:0] CT32   = 128'ha86842f2;
  localparam logic [127:0] PT64   = 128'h3b7265747475432d;
  localparam logic [255:0] K64    = 256'h1b1a1918131211100b0a090803020100;
  localparam logic [127:0] CT64   = 128'h8c6fa548454e028b;
  localparam logic [127:0] PT256  = 128'h65736f6874206e49202e72656e6f6f70;
  localparam logic [255:0] K256   = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT256  = 128'h4109010405c0f53e4eeeb48d9c188f43;

  typedef struct {
    logic [127:0] exp;
    int unsigned  e0;
  } exp_t;
  exp_t sbq [4][$];
  logic [127:0] last256_a = '0;

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic is_ready(input int id);
    case (id)
      0:       return d128_ready;
      1:       return d32_ready;
      2:       return d64_ready;
      default: return d256_ready;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic mon(input int id, input logic [127:0] ctx);
    exp_t e;
    if (sbq[id].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done[%0d]: got done=1 at cycle %0d required none", id, cyc);
    end else begin
      e = sbq[id].pop_front();
      check($sformatf("ct_xor[%0d]", id), ctx, e.exp);
      check($sformatf("latency[%0d]", id), 128'(cyc - e.e0), 128'(LAT[id]));
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (d128_done) mon(0, d128_ct_a ^ d128_ct_b);
      if (d32_done)  mon(1, 128'(d32_ct_a ^ d32_ct_b));
      if (d64_done)  mon(2, 128'(d64_ct_a ^ d64_ct_b));
      if (d256_done) begin
        mon(3, d256_ct_a ^ d256_ct_b);
        last256_a = d256_ct_a;
      end
    end
  endtask

  task automatic issue(input int id, input logic [127:0] pt, input logic [255:0] key,
                       input logic [127:0] pm, input logic [255:0] km,
                       input logic [127:0] ct, output int unsigned e0);
    int unsigned n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!is_ready(id) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_before_start[%0d]", id), 128'(is_ready(id)), 128'(1));
    case (id)
      0: begin
        d128_pt_a = pt ^ pm; d128_pt_b = pm;
        d128_key_a = key[127:0] ^ km[127:0]; d128_key_b = km[127:0]; d128_start = 1'b1;
      end
      1: begin
        d32_pt_a = pt[31:0] ^ pm[31:0]; d32_pt_b = pm[31:0];
        d32_key_a = key[63:0] ^ km[63:0]; d32_key_b = km[63:0]; d32_start = 1'b1;
      end
      2: begin
        d64_pt_a = pt[63:0] ^ pm[63:0]; d64_pt_b = pm[63:0];
        d64_key_a = key[127:0] ^ km[127:0]; d64_key_b = km[127:0]; d64_start = 1'b1;
      end
      default: begin
        d256_pt_a = pt ^ pm; d256_pt_b = pm;
        d256_key_a = key ^ km; d256_key_b = km; d256_start = 1'b1;
      end
    endcase
    @(posedge clk);
    #1;
    e0 = cyc;
    e.exp = ct;
    e.e0 = cyc;
    sbq[id].push_back(e);
    d128_start = 1'b0; d32_start = 1'b0; d64_start = 1'b0; d256_start = 1'b0;
    // inputs only matter in the accept cycle
    d128_pt_a = ~d128_pt_a; d32_pt_a = ~d32_pt_a; d64_pt_a = ~d64_pt_a; d256_pt_a = ~d256_pt_a;
    d128_key_b = ~d128_key_b; d32_key_b = ~d32_key_b; d64_key_b = ~d64_key_b; d256_key_b = ~d256_key_b;
  endtask

  task automatic wait_q(input int id);
    int unsigned n;
    n = 0;
    while (sbq[id].size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sbq[id].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: got no done within %0d cycles required done", id, n);
      sbq[id].delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rnd = 2'($urandom_range(0, 3));
    end
  end

  initial begin
    int unsigned e0;
    logic [127:0] first_a;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_ready", 128'(d128_ready), 128'(1));
    check("rst_busy",  128'(d128_busy),  128'(0));
    check("rst_done",  128'(d128_done),  128'(0));
    check("rst_ct_a",  d128_ct_a, '0);
    check("rst_ct_b",  d128_ct_b, '0);
    rst = 1'b0;

    issue(0, PT128, K128, '0, '0, CT128, e0);
    wait_q(0);

    issue(1, PT32, K32, rand256()[127:0], rand256(), CT32, e0);
    issue(2, PT64, K64, rand256()[127:0], rand256(), CT64, e0);
    issue(3, PT256, K256, rand256()[127:0], rand256(), CT256, e0);
    wait_q(1);
    wait_q(2);
    wait_q(3);
    first_a = last256_a;
    issue(3, PT256, K256, rand256()[127:0], rand256(), CT256, e0);
    wait_q(3);
    checks++;
    if (last256_a == first_a) begin
      errors++;
      $display("FAIL ct_a_remask: got %h both runs required differing shares", last256_a);
    end

    // reset in the middle of a run
    issue(0, PT128, K128, rand256()[127:0], rand256(), CT128, e0);
    while (cyc < e0 + 100) @(negedge clk);
    rst = 1'b1;
    sbq[0].delete();
    @(negedge clk);
    check("midrst_ct_a",  d128_ct_a, '0);
    check("midrst_ct_b",  d128_ct_b, '0);
    check("midrst_ready", 128'(d128_ready), 128'(1));
    check("midrst_busy",  128'(d128_busy),  128'(0));
    rst = 1'b0;
    issue(0, PT128, K128, rand256()[127:0], rand256(), CT128, e0);
    wait_q(0);

    // start pulses while busy, in DONE and in the done cycle are ignored
    issue(0, PT128, K128, rand256()[127:0], rand256(), CT128, e0);
    while (cyc < e0 + 40) @(negedge clk);
    d128_pt_a = ~d128_pt_a;
    d128_start = 1'b1;
    @(negedge clk);
    d128_start = 1'b0;
    while (cyc < e0 + LAT[0] - 1) @(negedge clk);
    d128_start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    d128_start = 1'b0;
    repeat (100) @(negedge clk);
    check("ignored_start_busy", 128'(d128_busy), 128'(0));
    check("ignored_start_ct", d128_ct_a ^ d128_ct_b, CT128);
    wait_q(0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
